gamepad_pmod_tx: RTL and testbench

GAMEPAD_PMOD_TX -- requirements
Module: gamepad_pmod_tx

---
 rtl/gamepad_pmod_pkg.sv | 31 +++
 rtl/gamepad_pmod_tx.sv | 150 +++++++++++++++
 tb/tb_gamepad_pmod_tx.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gamepad_pmod_pkg.sv
// Constants shared by the gamepad PMOD transmitter and receiver.
// Covers the button bit order, word/frame sizes and the word sent for a missing controller.
package gamepad_pmod_pkg;

    localparam int WORD_BITS  = 12;
    localparam int FRAME_BITS = 2 * WORD_BITS;

    localparam logic [WORD_BITS-1:0] ABSENT_WORD = 12'hFFF;

    // Bit positions within a 12-bit button word.
    localparam int BTN_B      = 11;
    localparam int BTN_Y      = 10;
    localparam int BTN_SELECT = 9;
    localparam int BTN_START  = 8;
    localparam int BTN_UP     = 7;
    localparam int BTN_DOWN   = 6;
    localparam int BTN_LEFT   = 5;
    localparam int BTN_RIGHT  = 4;
    localparam int BTN_A      = 3;
    localparam int BTN_X      = 2;
    localparam int BTN_L      = 1;
    localparam int BTN_R      = 0;

    function automatic logic [WORD_BITS-1:0] pad_word(
        input logic [WORD_BITS-1:0] buttons,
        input logic                 present
    );
        return present ? buttons : ABSENT_WORD;
    endfunction

endpackage

// File: rtl/gamepad_pmod_tx.sv
// Serialises two gamepad button words onto a PMOD clock/data/latch link.
// Each frame: 24 bits MSB first, a latch pulse, then an idle gap.
module gamepad_pmod_tx
    import gamepad_pmod_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [WORD_BITS-1:0] p1_buttons,
    input  logic [WORD_BITS-1:0] p2_buttons,
    input  logic                 p1_present,
    input  logic                 p2_present,
    output logic                 pmod_clk,
    output logic                 pmod_data,
    output logic                 pmod_latch,
    output logic                 busy,
    output logic                 frame_done
);

    typedef enum logic [2:0] {IDLE, LOW, HIGH, LATCH, GAP} state_t;

    // One 16-bit counter covers the longest phase: GAP_CYCLES up to 65535.
    localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
    localparam logic [15:0] LATCH_LAST = 16'(2 * CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);
    localparam logic [4:0]  IDX_TOP    = 5'(FRAME_BITS - 1);

    state_t                  r_state,      w_state_nxt;
    logic [15:0]             r_cnt,        w_cnt_nxt;
    logic [4:0]              r_index,      w_index_nxt;
    logic [FRAME_BITS-1:0]   r_frame,      w_frame_nxt;
    logic                    r_pmod_clk,   w_pmod_clk_nxt;
    logic                    r_pmod_data,  w_pmod_data_nxt;
    logic                    r_pmod_latch, w_pmod_latch_nxt;
    logic                    r_busy,       w_busy_nxt;
    logic                    r_frame_done, w_frame_done_nxt;

    logic [FRAME_BITS-1:0]   w_snapshot;
    logic [4:0]              w_index_dec;

    assign w_snapshot  = {pad_word(p1_buttons, p1_present), pad_word(p2_buttons, p2_present)};
    assign w_index_dec = r_index - 5'd1;

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt + 16'd1;
        w_index_nxt      = r_index;
        w_frame_nxt      = r_frame;
        w_pmod_clk_nxt   = r_pmod_clk;
        w_pmod_data_nxt  = r_pmod_data;
        w_pmod_latch_nxt = r_pmod_latch;
        w_busy_nxt       = r_busy;
        w_frame_done_nxt = 1'b0;

        unique case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (enable) begin
                    w_state_nxt     = LOW;
                    w_frame_nxt     = w_snapshot;
                    w_index_nxt     = IDX_TOP;
                    w_pmod_clk_nxt  = 1'b0;
                    w_pmod_data_nxt = w_snapshot[IDX_TOP];
                    w_busy_nxt      = 1'b1;
                end
            end
            LOW: begin
                if (r_cnt == DIV_LAST) begin
                    w_state_nxt    = HIGH;
                    w_cnt_nxt      = '0;
                    w_pmod_clk_nxt = 1'b1;
                end
            end
            HIGH: begin
                if (r_cnt == DIV_LAST) begin
                    w_cnt_nxt      = '0;
                    w_pmod_clk_nxt = 1'b0;
                    if (r_index == 5'd0) begin
                        w_state_nxt      = LATCH;
                        w_pmod_latch_nxt = 1'b1;
                    end else begin
                        w_state_nxt     = LOW;
                        w_index_nxt     = w_index_dec;
                        w_pmod_data_nxt = r_frame[w_index_dec];
                    end
                end
            end
            LATCH: begin
                if (r_cnt == LATCH_LAST) begin
                    w_state_nxt      = GAP;
                    w_cnt_nxt        = '0;
                    w_pmod_latch_nxt = 1'b0;
                    w_pmod_data_nxt  = 1'b0;
                    w_frame_done_nxt = 1'b1;
                end
            end
            GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt      = IDLE;
                w_cnt_nxt        = '0;
                w_pmod_clk_nxt   = 1'b0;
                w_pmod_data_nxt  = 1'b0;
                w_pmod_latch_nxt = 1'b0;
                w_busy_nxt       = 1'b0;
            end
        endcase
    end

    // NOTE: reset is sampled on the clock edge (synchronous) and all state uses <= so
    // every register updates from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_index      <= IDX_TOP;
            r_frame      <= '0;
            r_pmod_clk   <= 1'b0;
            r_pmod_data  <= 1'b0;
            r_pmod_latch <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_index      <= w_index_nxt;
            r_frame      <= w_frame_nxt;
            r_pmod_clk   <= w_pmod_clk_nxt;
            r_pmod_data  <= w_pmod_data_nxt;
            r_pmod_latch <= w_pmod_latch_nxt;
            r_busy       <= w_busy_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    assign pmod_clk   = r_pmod_clk;
    assign pmod_data  = r_pmod_data;
    assign pmod_latch = r_pmod_latch;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_gamepad_pmod_tx.sv
// Self-checking bench for gamepad_pmod_tx: default and fast parameter sets,
// with a frame scoreboard and a behavioural receiver on the serial link.
module tb_gamepad_pmod_tx;
    import gamepad_pmod_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic        en = 1'b0;
    logic [11:0] p1_b = '0, p2_b = '0;
    logic        p1_pr = 1'b0, p2_pr = 1'b0;
    logic        pclk, pdata, platch, busy, fdone;

    // Fast-parameter instance
    logic        f_en = 1'b0;
    logic [11:0] f_p1_b = '0, f_p2_b = '0;
    logic        f_p1_pr = 1'b0, f_p2_pr = 1'b0;
    logic        f_pclk, f_pdata, f_platch, f_busy, f_fdone;

    gamepad_pmod_tx dut (
        .clk(clk), .rst_n(rst_n), .enable(en),
        .p1_buttons(p1_b), .p2_buttons(p2_b),
        .p1_present(p1_pr), .p2_present(p2_pr),
        .pmod_clk(pclk), .pmod_data(pdata), .pmod_latch(platch),
        .busy(busy), .frame_done(fdone)
    );

    gamepad_pmod_tx #(.CLK_DIV(2), .GAP_CYCLES(1)) dut_fast (
        .clk(clk), .rst_n(rst_n), .enable(f_en),
        .p1_buttons(f_p1_b), .p2_buttons(f_p2_b),
        .p1_present(f_p1_pr), .p2_present(f_p2_pr),
        .pmod_clk(f_pclk), .pmod_data(f_pdata), .pmod_latch(f_platch),
        .busy(f_busy), .frame_done(f_fdone)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [23:0] exp_q[$];
    logic [23:0] fast_q[$];

    // Scoreboard monitor plus receiver model on the default instance
    logic [23:0] mon_sr, mon_exp;
    int          mon_bits, latch_seen;
    logic        prev_clk, prev_latch;
    logic [11:0] rx_p1, rx_p2;
    logic        rx_p1_pr, rx_p2_pr;

    initial begin : monitor
        mon_sr = '0; mon_bits = 0; latch_seen = 0;
        prev_clk = 1'b0; prev_latch = 1'b0;
        rx_p1 = '0; rx_p2 = '0; rx_p1_pr = 1'b0; rx_p2_pr = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_sr = '0;
                mon_bits = 0;
            end else begin
                if (pclk && !prev_clk) begin
                    mon_sr = {mon_sr[22:0], pdata};
                    mon_bits++;
                end
                if (platch && !prev_latch) begin
                    latch_seen++;
                    rx_p1    = mon_sr[23:12];
                    rx_p2    = mon_sr[11:0];
                    rx_p1_pr = (mon_sr[23:12] != ABSENT_WORD);
                    rx_p2_pr = (mon_sr[11:0] != ABSENT_WORD);
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_latch: got frame %h after %0d bits, required no latch", mon_sr, mon_bits);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        if (mon_sr !== mon_exp || mon_bits != 24) begin
                            bad++;
                            $display("FAIL frame: got %h (%0d bits), required %h (24 bits)", mon_sr, mon_bits, mon_exp);
                        end
                    end
                    mon_bits = 0;
                end
            end
            prev_clk   = pclk;
            prev_latch = platch;
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_enable();
        en = 1'b1;
        step();
        en = 1'b0;
    endtask

    // Runs from just after the enable edge until busy drops; measures the frame.
    task automatic run_frame(output int len, output int lat, output int dn, output int done_ok);
        logic prev_l;
        len = 0; lat = 0; dn = 0; done_ok = 0; prev_l = 1'b0;
        while (busy && len < 1000) begin
            if (platch) lat++;
            if (fdone) begin
                dn++;
                if (prev_l && !platch) done_ok = 1;
            end
            prev_l = platch;
            step();
            len++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        total += 6;
        if (pclk !== 1'b0)   begin bad++; $display("FAIL reset_pmod_clk: got %b, required 0", pclk); end
        if (pdata !== 1'b0)  begin bad++; $display("FAIL reset_pmod_data: got %b, required 0", pdata); end
        if (platch !== 1'b0) begin bad++; $display("FAIL reset_pmod_latch: got %b, required 0", platch); end
        if (busy !== 1'b0)   begin bad++; $display("FAIL reset_busy: got %b, required 0", busy); end
        if (fdone !== 1'b0)  begin bad++; $display("FAIL reset_frame_done: got %b, required 0", fdone); end
        if (f_busy !== 1'b0) begin bad++; $display("FAIL reset_fast_busy: got %b, required 0", f_busy); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_frame();
        int len, lat, dn, ok, seen0;
        p1_b = 12'h801; p1_pr = 1'b1;
        p2_b = 12'h123; p2_pr = 1'b0;
        exp_q.push_back(24'h801FFF);
        seen0 = latch_seen;
        pulse_enable();
        total += 2;
        if (busy !== 1'b1)  begin bad++; $display("FAIL first_busy: got %b, required 1", busy); end
        if (pdata !== 1'b1) begin bad++; $display("FAIL first_data: got %b, required 1", pdata); end
        run_frame(len, lat, dn, ok);
        total += 5;
        if (len != 216)  begin bad++; $display("FAIL frame_len: got %0d, required 216", len); end
        if (lat != 8)    begin bad++; $display("FAIL latch_len: got %0d, required 8", lat); end
        if (dn != 1)     begin bad++; $display("FAIL done_pulses: got %0d, required 1", dn); end
        if (ok != 1)     begin bad++; $display("FAIL done_after_latch: got %0d, required 1", ok); end
        if (latch_seen - seen0 != 1) begin bad++; $display("FAIL latch_count: got %0d, required 1", latch_seen - seen0); end
        step();
    endtask

    task automatic test_loopback();
        int len, lat, dn, ok;
        p1_b = 12'h0A5; p1_pr = 1'b1;
        p2_b = 12'h35C; p2_pr = 1'b1;
        exp_q.push_back(24'h0A535C);
        pulse_enable();
        run_frame(len, lat, dn, ok);
        total += 5;
        if (rx_p1 !== 12'h0A5)  begin bad++; $display("FAIL rx_p1: got %h, required 0a5", rx_p1); end
        if (rx_p2 !== 12'h35C)  begin bad++; $display("FAIL rx_p2: got %h, required 35c", rx_p2); end
        if (rx_p1_pr !== 1'b1)  begin bad++; $display("FAIL rx_p1_present: got %b, required 1", rx_p1_pr); end
        if (rx_p2_pr !== 1'b1)  begin bad++; $display("FAIL rx_p2_present: got %b, required 1", rx_p2_pr); end
        if (len != 216)         begin bad++; $display("FAIL loop_len: got %0d, required 216", len); end
        step();
    endtask

    task automatic test_back_to_back();
        int t[3];
        int nd, n, hi_run, lo_run, hi_total, duty_bad, seen0;
        logic pb, pc, in_bits;
        p1_b = 12'h123; p1_pr = 1'b1;
        p2_b = 12'h456; p2_pr = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(24'h123456);
        seen0 = latch_seen;
        nd = 0; n = 0; hi_run = 0; lo_run = 0; hi_total = 0; duty_bad = 0; in_bits = 1'b0;
        pb = busy; pc = pclk;
        en = 1'b1;
        while (nd < 3 && n < 1000) begin
            step();
            n++;
            if (busy && !pb) in_bits = 1'b1;
            if (platch) in_bits = 1'b0;
            if (pclk) begin
                if (!pc) begin
                    if (lo_run != 4) duty_bad++;
                    lo_run = 0;
                end
                hi_run++;
                hi_total++;
            end else begin
                if (pc) begin
                    if (hi_run != 4) duty_bad++;
                    hi_run = 0;
                end
                if (in_bits) lo_run++;
            end
            if (fdone) begin
                t[nd] = cyc;
                nd++;
            end
            pb = busy; pc = pclk;
        end
        en = 1'b0;
        n = 0;
        while (busy && n < 100) begin step(); n++; end
        repeat (10) step();
        total += 6;
        if (nd != 3)              begin bad++; $display("FAIL b2b_dones: got %0d, required 3", nd); end
        if (t[1] - t[0] != 217)   begin bad++; $display("FAIL b2b_space1: got %0d, required 217", t[1] - t[0]); end
        if (t[2] - t[1] != 217)   begin bad++; $display("FAIL b2b_space2: got %0d, required 217", t[2] - t[1]); end
        if (hi_total != 288)      begin bad++; $display("FAIL b2b_high_cycles: got %0d, required 288", hi_total); end
        if (duty_bad != 0)        begin bad++; $display("FAIL b2b_duty: got %0d bad runs, required 0", duty_bad); end
        if (latch_seen - seen0 != 3) begin bad++; $display("FAIL b2b_frames: got %0d, required 3", latch_seen - seen0); end
    endtask

    task automatic test_mid_frame_change();
        int n, nd, seen0;
        p1_b = 12'h000; p1_pr = 1'b1;
        p2_b = 12'h0AA; p2_pr = 1'b1;
        exp_q.push_back(24'h0000AA);
        exp_q.push_back(24'hFFF0AA);
        seen0 = latch_seen;
        en = 1'b1;
        n = 0;
        while (mon_bits < 14 && n < 400) begin step(); n++; end
        p1_b = 12'hFFF;
        nd = 0; n = 0;
        while (nd < 2 && n < 1000) begin
            step();
            n++;
            if (fdone) nd++;
        end
        en = 1'b0;
        n = 0;
        while (busy && n < 100) begin step(); n++; end
        step();
        total += 2;
        if (latch_seen - seen0 != 2) begin bad++; $display("FAIL change_frames: got %0d, required 2", latch_seen - seen0); end
        if (exp_q.size() != 0)       begin bad++; $display("FAIL change_pending: got %0d, required 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_frame();
        int n, lat_cnt, seen0, len, lat, dn, ok;
        p1_b = 12'h5A5; p1_pr = 1'b1;
        p2_b = 12'h000; p2_pr = 1'b0;
        seen0 = latch_seen;
        pulse_enable();
        n = 0;
        while (mon_bits < 5 && n < 200) begin step(); n++; end
        rst_n = 1'b0;
        step();
        total += 4;
        if ({pclk, pdata, platch} !== 3'b000) begin bad++; $display("FAIL abort_pmod: got %b, required 000", {pclk, pdata, platch}); end
        if ({busy, fdone} !== 2'b00)          begin bad++; $display("FAIL abort_status: got %b, required 00", {busy, fdone}); end
        rst_n = 1'b1;
        lat_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (platch || busy) lat_cnt++;
        end
        if (lat_cnt != 0)              begin bad++; $display("FAIL abort_quiet: got %0d active cycles, required 0", lat_cnt); end
        if (latch_seen - seen0 != 0)   begin bad++; $display("FAIL abort_latch: got %0d, required 0", latch_seen - seen0); end
        p1_b = 12'h3C3;
        exp_q.push_back(24'h3C3FFF);
        pulse_enable();
        run_frame(len, lat, dn, ok);
        total += 2;
        if (len != 216)                begin bad++; $display("FAIL after_reset_len: got %0d, required 216", len); end
        if (latch_seen - seen0 != 1)   begin bad++; $display("FAIL after_reset_frames: got %0d, required 1", latch_seen - seen0); end
        step();
    endtask

    task automatic test_fast();
        int len, rises, unstable;
        logic pc, pd, pl;
        logic [23:0] sr, ex;
        f_p1_b = 12'hA5A; f_p1_pr = 1'b1;
        f_p2_b = 12'h0F0; f_p2_pr = 1'b1;
        fast_q.push_back(24'hA5A0F0);
        f_en = 1'b1;
        step();
        f_en = 1'b0;
        len = 0; rises = 0; unstable = 0; sr = '0;
        pc = f_pclk; pd = f_pdata; pl = f_platch;
        while (f_busy && len < 500) begin
            step();
            len++;
            if (f_pclk && !pc) begin
                rises++;
                if (f_pdata !== pd) unstable++;
                sr = {sr[22:0], f_pdata};
            end
            if (f_platch && !pl) begin
                total++;
                if (fast_q.size() == 0) begin
                    bad++;
                    $display("FAIL fast_unexpected_latch: got frame %h, required no latch", sr);
                end else begin
                    ex = fast_q.pop_front();
                    if (sr !== ex) begin bad++; $display("FAIL fast_frame: got %h, required %h", sr, ex); end
                end
            end
            pc = f_pclk; pd = f_pdata; pl = f_platch;
        end
        total += 4;
        if (len != 101)          begin bad++; $display("FAIL fast_len: got %0d, required 101", len); end
        if (rises != 24)         begin bad++; $display("FAIL fast_rises: got %0d, required 24", rises); end
        if (unstable != 0)       begin bad++; $display("FAIL fast_stable: got %0d changes at rise, required 0", unstable); end
        if (fast_q.size() != 0)  begin bad++; $display("FAIL fast_pending: got %0d, required 0", fast_q.size()); end
    endtask

    initial begin : main
        test_reset();
        test_single_frame();
        test_loopback();
        test_back_to_back();
        test_mid_frame_change();
        test_reset_mid_frame();
        test_fast();
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_pending: got %0d, required 0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
